// File: rtl/bp_be_pkg.sv
// Back-end shared types: processor configuration and internal-interface structs.
package bp_be_pkg;

    typedef enum logic {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int dword_width_gp    = 64;
    localparam int reg_addr_width_gp = 5;

    // Dword width selected by a processor configuration.
    function automatic int dword_width_f(bp_params_e cfg);
        unique case (cfg)
            e_bp_default_cfg: return dword_width_gp;
            default:          return dword_width_gp;
        endcase
    endfunction

    // Register address width selected by a processor configuration.
    function automatic int reg_addr_width_f(bp_params_e cfg);
        unique case (cfg)
            e_bp_default_cfg: return reg_addr_width_gp;
            default:          return reg_addr_width_gp;
        endcase
    endfunction

    // One integer writeback stage entry.
    typedef struct packed {
        logic                         valid;
        logic                         w_v;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [dword_width_gp-1:0]    data;
    } bp_be_int_wb_entry_s;

endpackage

// File: rtl/bp_be_int_wb_stage.sv
// One writeback stage register. Only the valid bit is reset; the payload
// is meaningless while valid is low. A load takes priority over a clear.
module bp_be_int_wb_stage
    import bp_be_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic                clr_i,
    input  bp_be_int_wb_entry_s entry_i,
    output bp_be_int_wb_entry_s entry_o
);

    logic                         valid_r;
    logic                         w_v_r;
    logic [reg_addr_width_gp-1:0] rd_addr_r;
    logic [dword_width_gp-1:0]    data_r;

    // Valid bit: async clear on reset, load on enable, drop on clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            valid_r <= 1'b0;
        else if (en_i)
            valid_r <= entry_i.valid;
        else if (clr_i)
            valid_r <= 1'b0;
    end

    // Payload captured on enable, otherwise held.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            w_v_r     <= entry_i.w_v;
            rd_addr_r <= entry_i.rd_addr;
            data_r    <= entry_i.data;
        end
    end

    assign entry_o = {valid_r, w_v_r, rd_addr_r, data_r};

endmodule

// File: rtl/bp_be_int_wb_pipe.sv
// Integer writeback pipe: stage A (uncommitted, flushable) feeds stage B
// (committed, drives the register-file write port and may stall on yumi).
module bp_be_int_wb_pipe
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p   = e_bp_default_cfg,
    parameter int         wcnt_width_p  = 16,
    localparam int        dword_w_lp    = dword_width_f(bp_params_p),
    localparam int        addr_w_lp     = reg_addr_width_f(bp_params_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             v_i,
    input  logic [dword_w_lp-1:0]            data_i,
    input  logic [addr_w_lp-1:0]             rd_addr_i,
    input  logic                             rd_w_v_i,
    output logic                             ready_o,
    input  logic                             flush_i,
    output logic [1:0]                       bypass_v_o,
    output logic [1:0][addr_w_lp-1:0]        bypass_addr_o,
    output logic [1:0][dword_w_lp-1:0]       bypass_data_o,
    output logic                             rf_w_v_o,
    output logic [addr_w_lp-1:0]             rf_w_addr_o,
    output logic [dword_w_lp-1:0]            rf_w_data_o,
    input  logic                             rf_w_yumi_i,
    output logic [wcnt_width_p-1:0]          wcnt_o
);

    bp_be_int_wb_entry_s in_entry, a_entry, b_entry;
    logic b_retire, a_adv, accept;
    logic [wcnt_width_p-1:0] wcnt_r;

    // Handshake: B leaves when its write is taken or it has nothing to write;
    // A moves up whenever B is free by the end of this cycle.
    always_comb begin
        b_retire = b_entry.valid & (~b_entry.w_v | rf_w_yumi_i);
        a_adv    = a_entry.valid & (~b_entry.valid | b_retire);
        ready_o  = ~(a_entry.valid & ~a_adv);
        accept   = v_i & ready_o & ~flush_i;
    end

    // Incoming entry; writes to x0 are neutralised at capture.
    always_comb begin
        in_entry         = '0;
        in_entry.valid   = 1'b1;
        in_entry.w_v     = rd_w_v_i & (rd_addr_i != '0);
        in_entry.rd_addr = rd_addr_i;
        in_entry.data    = data_i;
    end

    bp_be_int_wb_stage stage_a (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (accept),
        .clr_i   (flush_i | a_adv),
        .entry_i (in_entry),
        .entry_o (a_entry)
    );

    // A flushed while advancing delivers nothing to B.
    bp_be_int_wb_stage stage_b (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (a_adv & ~flush_i),
        .clr_i   (b_retire),
        .entry_i (a_entry),
        .entry_o (b_entry)
    );

    // Forwarding and write-port outputs.
    always_comb begin
        bypass_v_o[0]    = a_entry.valid & a_entry.w_v;
        bypass_v_o[1]    = b_entry.valid & b_entry.w_v;
        bypass_addr_o[0] = a_entry.rd_addr;
        bypass_addr_o[1] = b_entry.rd_addr;
        bypass_data_o[0] = a_entry.data;
        bypass_data_o[1] = b_entry.data;
        rf_w_v_o         = b_entry.valid & b_entry.w_v;
        rf_w_addr_o      = b_entry.rd_addr;
        rf_w_data_o      = b_entry.data;
    end

    // Retired-write counter, wraps naturally.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            wcnt_r <= '0;
        else if (rf_w_v_o & rf_w_yumi_i)
            wcnt_r <= wcnt_r + wcnt_width_p'(1);
    end

    assign wcnt_o = wcnt_r;

endmodule

// File: tb/tb_bp_be_int_wb_pipe.sv
// Bench for bp_be_int_wb_pipe: queue-based reference model compared every
// negedge, plus directed scenarios with literal expectations.
module tb_bp_be_int_wb_pipe;
    import bp_be_pkg::*;

    localparam int WC = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              v_i = 1'b0;
    logic [63:0]       data_i = '0;
    logic [4:0]        rd_addr_i = '0;
    logic              rd_w_v_i = 1'b0;
    logic              ready_o;
    logic              flush_i = 1'b0;
    logic [1:0]        bypass_v_o;
    logic [1:0][4:0]   bypass_addr_o;
    logic [1:0][63:0]  bypass_data_o;
    logic              rf_w_v_o;
    logic [4:0]        rf_w_addr_o;
    logic [63:0]       rf_w_data_o;
    logic              yumi = 1'b0;
    logic [WC-1:0]     wcnt_o;

    int n_chk = 0;
    int n_fail = 0;

    bp_be_int_wb_pipe #(.bp_params_p(e_bp_default_cfg), .wcnt_width_p(WC)) dut (
        .clk_i(clk), .reset_i(rst), .v_i(v_i), .data_i(data_i),
        .rd_addr_i(rd_addr_i), .rd_w_v_i(rd_w_v_i), .ready_o(ready_o),
        .flush_i(flush_i), .bypass_v_o(bypass_v_o), .bypass_addr_o(bypass_addr_o),
        .bypass_data_o(bypass_data_o), .rf_w_v_o(rf_w_v_o), .rf_w_addr_o(rf_w_addr_o),
        .rf_w_data_o(rf_w_data_o), .rf_w_yumi_i(yumi), .wcnt_o(wcnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: in-order list of entries, oldest first, each tagged
    // as committed (in B) or not (in A).
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
        bit          wv;
        bit          in_b;
    } ent_t;

    ent_t         m_q[$];
    logic [WC-1:0] m_cnt;

    function automatic bit m_has_b();
        return m_q.size() > 0 && m_q[0].in_b;
    endfunction

    function automatic bit m_has_a();
        return m_q.size() > 0 && !m_q[m_q.size()-1].in_b;
    endfunction

    function automatic bit m_ready(input bit y);
        bit b_leaves;
        b_leaves = m_has_b() && (!m_q[0].wv || y);
        return !(m_has_a() && m_has_b() && !b_leaves);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_cnt = '0;
        end else begin
            bit rdy;
            ent_t e;
            rdy = m_ready(yumi);
            if (m_has_b() && (!m_q[0].wv || yumi)) begin
                if (m_q[0].wv) m_cnt = m_cnt + 1'b1;
                void'(m_q.pop_front());
            end
            if (flush_i) begin
                if (m_has_a()) void'(m_q.pop_back());
            end else if (m_has_a() && !m_has_b()) begin
                m_q[m_q.size()-1].in_b = 1'b1;
            end
            if (v_i && rdy && !flush_i) begin
                e.rd = rd_addr_i; e.d = data_i;
                e.wv = rd_w_v_i && (rd_addr_i != 5'd0); e.in_b = 1'b0;
                m_q.push_back(e);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        bit hb, ha, ewv;
        ent_t ea, eb;
        hb = m_has_b(); ha = m_has_a();
        if (hb) eb = m_q[0];
        if (ha) ea = m_q[m_q.size()-1];
        ewv = hb && eb.wv;
        chk("m_ready", ready_o, m_ready(yumi));
        chk("m_rf_w_v", rf_w_v_o, ewv);
        chk("m_wcnt", wcnt_o, m_cnt);
        chk("m_byp_a_v", bypass_v_o[0], ha && ea.wv);
        chk("m_byp_b_v", bypass_v_o[1], ewv);
        if (ewv) begin
            chk("m_rf_addr", rf_w_addr_o, eb.rd);
            chk("m_rf_data", rf_w_data_o, eb.d);
        end
        if (ha && ea.wv) begin
            chk("m_byp_a_addr", bypass_addr_o[0], ea.rd);
            chk("m_byp_a_data", bypass_data_o[0], ea.d);
        end
    end

    // Log of accepted register-file writes.
    logic [4:0] wlog[$];
    always @(posedge clk) if (!rst && rf_w_v_o && yumi) wlog.push_back(rf_w_addr_o);

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [63:0] d);
        v_i = 1'b1; rd_addr_i = rd; data_i = d; rd_w_v_i = 1'b1;
    endtask

    task automatic do_reset();
        v_i = 1'b0; flush_i = 1'b0; yumi = 1'b0; rd_w_v_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wlog.delete();
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_rf_w_v", rf_w_v_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_wcnt", wcnt_o, 0);
        chk("rst_byp_v", bypass_v_o, 0);
        do_reset();

        // single write, rd=5
        yumi = 1'b1; drive(5'd5, 64'h1234);
        cyc();
        chk("t1_byp_v", bypass_v_o, 2'b01);
        chk("t1_byp_addr", bypass_addr_o[0], 5);
        chk("t1_no_wr_yet", rf_w_v_o, 0);
        v_i = 1'b0;
        cyc();
        chk("t1_rf_w_v", rf_w_v_o, 1);
        chk("t1_rf_addr", rf_w_addr_o, 5);
        chk("t1_rf_data", rf_w_data_o, 64'h1234);
        cyc();
        chk("t1_wcnt", wcnt_o, 1);
        chk("t1_idle", rf_w_v_o, 0);

        // rd=0 never writes
        do_reset(); yumi = 1'b1; drive(5'd0, 64'habc);
        cyc(); chk("t2_byp_v", bypass_v_o, 0); v_i = 1'b0;
        cyc(); chk("t2_rf_w_v", rf_w_v_o, 0); chk("t2_byp_v2", bypass_v_o, 0);
        cyc(); chk("t2_wcnt", wcnt_o, 0);

        // stall with back-to-back inputs
        do_reset(); drive(5'd1, 64'h11);
        cyc(); chk("t3_ready1", ready_o, 1); drive(5'd2, 64'h22);
        cyc(); chk("t3_ready2", ready_o, 0); chk("t3_addr_e2", rf_w_addr_o, 1);
        drive(5'd3, 64'h33);
        cyc(); chk("t3_ready3", ready_o, 0); chk("t3_addr_e3", rf_w_addr_o, 1);
        chk("t3_byp_a", bypass_addr_o[0], 2);
        cyc(); chk("t3_addr_e4", rf_w_addr_o, 1); chk("t3_wcnt_stall", wcnt_o, 0);
        yumi = 1'b1; #1; chk("t3_ready_yumi", ready_o, 1);
        cyc(); chk("t3_wcnt1", wcnt_o, 1); chk("t3_addr2", rf_w_addr_o, 2); v_i = 1'b0;
        cyc(); chk("t3_wcnt2", wcnt_o, 2); chk("t3_addr3", rf_w_addr_o, 3);
        cyc(); chk("t3_wcnt3", wcnt_o, 3); chk("t3_idle", rf_w_v_o, 0);
        chk("t3_log_n", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("t3_log0", wlog[0], 1); chk("t3_log1", wlog[1], 2); chk("t3_log2", wlog[2], 3);
        end

        // flush A (rd=7) while B stalls (rd=3)
        do_reset(); drive(5'd3, 64'h33);
        cyc(); drive(5'd7, 64'h77);
        cyc(); chk("t4_byp_v", bypass_v_o, 2'b11); v_i = 1'b0; flush_i = 1'b1;
        cyc(); flush_i = 1'b0;
        chk("t4_byp_v_fl", bypass_v_o, 2'b10); chk("t4_addr", rf_w_addr_o, 3);
        yumi = 1'b1;
        cyc(); chk("t4_wcnt", wcnt_o, 1);
        cyc(); cyc(); chk("t4_wcnt_end", wcnt_o, 1); chk("t4_idle", rf_w_v_o, 0);
        chk("t4_log_n", wlog.size(), 1);
        if (wlog.size() == 1) chk("t4_log0", wlog[0], 3);

        // flush drops a same-cycle input
        do_reset(); yumi = 1'b1; flush_i = 1'b1; drive(5'd9, 64'h99);
        cyc(); flush_i = 1'b0; v_i = 1'b0; chk("t4b_byp_v", bypass_v_o, 0);
        cyc(); cyc(); chk("t4b_wcnt", wcnt_o, 0);

        // flush while A advances: B gets nothing
        do_reset(); yumi = 1'b1; drive(5'd4, 64'h44);
        cyc(); v_i = 1'b0; flush_i = 1'b1;
        cyc(); flush_i = 1'b0; chk("t4c_rf_w_v", rf_w_v_o, 0); chk("t4c_byp_v", bypass_v_o, 0);
        cyc(); chk("t4c_wcnt", wcnt_o, 0);

        // 17 writes wrap a 4-bit counter to 1
        do_reset(); yumi = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(5'(i + 1), 64'(i));
            cyc();
        end
        v_i = 1'b0;
        cyc(); cyc(); cyc();
        chk("t5_wcnt_wrap", wcnt_o, 1);

        // async reset in the middle of a stall
        do_reset(); yumi = 1'b1; drive(5'd2, 64'h22);
        cyc(); v_i = 1'b0;
        cyc(); cyc(); chk("t6_wcnt_pre", wcnt_o, 1);
        yumi = 1'b0; drive(5'd6, 64'h66);
        cyc(); drive(5'd8, 64'h88);
        cyc(); v_i = 1'b0; chk("t6_stall", rf_w_v_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rf_w_v", rf_w_v_o, 0); chk("t6_ready", ready_o, 1);
        chk("t6_wcnt", wcnt_o, 0); chk("t6_byp_v", bypass_v_o, 0);
        @(negedge clk); #1 rst = 1'b0;
        yumi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("t6_no_wr", rf_w_v_o, 0);
        end
        chk("t6_wcnt_end", wcnt_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_be_int_wb_pipe.md
BP_BE_INT_WB_PIPE -- requirements
Module: bp_be_int_wb_pipe

Interface
REQ-001 SHALL take parameter bp_params_p, default e_bp_default_cfg; selects processor configuration (dword width 64, register address width 5).
REQ-002 SHALL take parameter wcnt_width_p, default 16; width of the retired-write counter.
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port v_i, input, 1: integer-pipe result valid.
REQ-006 SHALL have port data_i, input, 64: integer-pipe result.
REQ-007 SHALL have port rd_addr_i, input, 5: destination register.
REQ-008 SHALL have port rd_w_v_i, input, 1: instruction writes rd.
REQ-009 SHALL have port ready_o, output, 1: entry accepted this cycle when v_i & ready_o.
REQ-010 SHALL have port flush_i, input, 1: kill uncommitted work.
REQ-011 SHALL have port bypass_v_o, output, 2: per-stage forwarding valid ([0]=stage A, [1]=stage B).
REQ-012 SHALL have port bypass_addr_o, output, 2x5: per-stage rd.
REQ-013 SHALL have port bypass_data_o, output, 2x64: per-stage data.
REQ-014 SHALL have port rf_w_v_o, output, 1: register-file write request.
REQ-015 SHALL have port rf_w_addr_o, output, 5: write address.
REQ-016 SHALL have port rf_w_data_o, output, 64: write data.
REQ-017 SHALL have port rf_w_yumi_i, input, 1: write accepted; legal only while rf_w_v_o.
REQ-018 SHALL have port wcnt_o, output, wcnt_width_p: count of accepted register-file writes.

Function
REQ-019 SHALL implement two registered stages: A (uncommitted) then B (committed, drives the write port); latency is 2 cycles from acceptance to rf_w_v_o with no stall.
REQ-020 SHALL clear the write-enable of an accepted entry when rd_addr_i==0, while the entry still occupies its stage.
REQ-021 SHALL assert rf_w_v_o iff B is valid with a write-enable set; rf_w_addr_o and rf_w_data_o come from B.
REQ-022 SHALL hold B while rf_w_v_o & ~rf_w_yumi_i (stall); B with no write-enable retires unconditionally in one cycle.
REQ-023 SHALL advance A into B when B is empty or retiring this cycle; otherwise A holds.
REQ-024 SHALL drive ready_o = ~(A valid & A not advancing); it is combinational, not dependent on v_i.
REQ-025 SHALL on flush_i invalidate A and drop any same-cycle input; B is never flushed.
REQ-026 SHALL on flush_i with A advancing the same cycle drop A's entry; B receives nothing.
REQ-027 SHALL drive bypass_v_o[i] = stage valid & write-enable; stage A forwarding remains valid until flushed.
REQ-028 SHALL increment wcnt_o by 1 per cycle with rf_w_v_o & rf_w_yumi_i, wrapping from all-ones to 0.

Reset
REQ-029 SHALL on reset_i asynchronously clear A/B valid bits and wcnt_o to 0; rf_w_v_o, bypass_v_o =0 and ready_o =1 immediately.
REQ-030 SHALL leave data/address registers unreset; outputs derived from them are don't-care while the corresponding valid is 0.
REQ-031 SHALL discard an in-progress stalled write on reset mid-operation; no write issued after deassertion until a new entry arrives.

Structure
REQ-032 SHALL declare the stage entry struct (valid, w_v, rd_addr, data) in bp_be_pkg alongside the other internal-interface structs.
REQ-033 SHALL instantiate one sub-module, bp_be_int_wb_stage, for each stage register (enable, clear, async reset of valid).

Verification
REQ-034 Bench SHALL cover: accept rd=5,data=0x1234, yumi tied 1 -> rf_w_v_o cycle+2, addr 5, data 0x1234, wcnt_o=1.
REQ-035 Bench SHALL cover: rd=0 entry -> no rf_w_v_o, bypass_v_o=0 throughout, wcnt_o unchanged.
REQ-036 Bench SHALL cover: yumi held 0 for 3 cycles with 3 back-to-back inputs -> ready_o drops after 2nd accepted, B/A hold, in-order writes resume on yumi.
REQ-037 Bench SHALL cover: flush_i while A holds rd=7 and B stalls rd=3 -> rd=7 never written, rd=3 written after yumi.
REQ-038 Bench SHALL cover: wcnt_width_p=4, 17 writes -> wcnt_o=1.
REQ-039 Bench SHALL cover: reset_i asserted mid-clock during stall -> rf_w_v_o falls before next edge, ready_o=1, wcnt_o=0.
